ultrasonic_scheduler: RTL

ULTRASONIC_SCHEDULER -- requirements
Module: ultrasonic_scheduler

---
 rtl/ultrasonic_scheduler_pkg.sv | 7 +
 rtl/ultrasonic_scheduler_if.sv | 14 +
 rtl/ultrasonic_scheduler_echo_sync.sv | 12 +
 rtl/ultrasonic_scheduler.sv | 91 +++++++++
 4 files changed

// File: rtl/ultrasonic_scheduler_pkg.sv
// ultrasonic_pkg: shared state, distance type and constants for the ultrasonic scheduler
package ultrasonic_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, GAP} state_t;
  typedef logic [8:0] dist_t;
  localparam dist_t NO_ECHO = 9'h1FF;
  localparam dist_t MAX_CM = 9'd400;
endpackage

// File: rtl/ultrasonic_scheduler_if.sv
// ultrasonic_scheduler_if: control, echo/trigger lines and result bus of the scheduler
interface ultrasonic_scheduler_if #(parameter int N_SENSORS = 3);
  import ultrasonic_pkg::*;
  logic enable;
  logic [N_SENSORS-1:0] echo;
  logic [N_SENSORS-1:0] trig;
  dist_t [N_SENSORS-1:0] distance;
  logic [N_SENSORS-1:0] timeout;
  logic [N_SENSORS-1:0] too_close;
  logic meas_valid;
  logic [2:0] meas_id;
  modport master (output enable, echo, input trig, distance, timeout, too_close, meas_valid, meas_id);
  modport slave (input enable, echo, output trig, distance, timeout, too_close, meas_valid, meas_id);
endinterface

// File: rtl/ultrasonic_scheduler_echo_sync.sv
// echo_sync: per-bit two-flop synchronizer for the asynchronous echo lines
module echo_sync #(parameter int W = 1) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {o_q, r_meta} <= '0;
    else {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/ultrasonic_scheduler.sv
// ultrasonic_scheduler: round-robin trigger/echo timing of time-shared ultrasonic rangers
module ultrasonic_scheduler
  import ultrasonic_pkg::*;
#(
  parameter int N_SENSORS      = 3,
  parameter int TRIG_CYCLES    = 500,
  parameter int CM_CYCLES      = 2900,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 2_500_000,
  parameter int CLOSE_CM       = 50,
  parameter int HYST_CM        = 5
) (
  input logic clk,
  input logic rst_n,
  ultrasonic_scheduler_if.slave bus
);
  localparam int TG_MAX = TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = TG_MAX > TRIG_CYCLES ? TG_MAX : TRIG_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int SW = $clog2(CM_CYCLES + 1);
  localparam int SLW = N_SENSORS > 1 ? $clog2(N_SENSORS) : 1;
  state_t r_state, w_next;
  logic [SLW-1:0] r_slot;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_sub;
  dist_t r_cm;
  logic r_prev;
  logic [N_SENSORS-1:0] w_echo;
  logic w_e, w_rise, w_trig_done, w_to, w_gap_done, w_done, w_res_to;
  echo_sync #(.W(N_SENSORS)) u_sync (.clk(clk), .rst_n(rst_n), .i_d(bus.echo), .o_q(w_echo));
  assign w_e = w_echo[r_slot];
  // a rise needs a low sample first, so echo already high on entry is ignored
  assign w_rise = w_e & ~r_prev;
  assign w_trig_done = r_cnt == CW'(TRIG_CYCLES - 1);
  assign w_to = r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_gap_done = r_cnt == CW'(GAP_CYCLES - 1);
  assign w_done = bus.enable & ((r_state == WAIT_RISE & ~w_rise & w_to) | (r_state == MEASURE & (~w_e | w_to)));
  assign w_res_to = r_state == WAIT_RISE | w_e;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      w_next = bus.enable ? TRIG : IDLE;
      TRIG:      w_next = !bus.enable ? IDLE : w_trig_done ? WAIT_RISE : TRIG;
      WAIT_RISE: w_next = !bus.enable ? IDLE : w_rise ? MEASURE : w_to ? GAP : WAIT_RISE;
      MEASURE:   w_next = !bus.enable ? IDLE : (!w_e || w_to) ? GAP : MEASURE;
      GAP:       w_next = !w_gap_done ? GAP : bus.enable ? TRIG : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.trig = '0;
    if (r_state == TRIG) bus.trig[r_slot] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_slot <= '0;
      r_cnt <= '0;
      r_sub <= '0;
      r_cm <= '0;
      r_prev <= 1'b0;
      bus.distance <= {N_SENSORS{NO_ECHO}};
      bus.timeout <= '0;
      bus.too_close <= '0;
      bus.meas_valid <= 1'b0;
      bus.meas_id <= '0;
    end else begin
      r_prev <= w_e;
      bus.meas_valid <= w_done;
      // the rise cycle is the first echo-high cycle, so MEASURE starts at one
      r_cnt <= (w_next == MEASURE && r_state != MEASURE) ? CW'(1) :
               (w_next != r_state || r_state == IDLE) ? '0 : r_cnt + CW'(1);
      if (w_next == MEASURE && r_state != MEASURE) begin
        r_sub <= SW'(1);
        r_cm <= '0;
      end else if (r_state == MEASURE && w_e) begin
        r_sub <= (r_sub == SW'(CM_CYCLES - 1)) ? '0 : r_sub + SW'(1);
        if (r_sub == SW'(CM_CYCLES - 1) && r_cm != MAX_CM) r_cm <= r_cm + 9'd1;
      end
      if (r_state == GAP && w_gap_done) r_slot <= (r_slot == SLW'(N_SENSORS - 1)) ? '0 : r_slot + SLW'(1);
      if (w_done) begin
        bus.distance[r_slot] <= w_res_to ? NO_ECHO : r_cm;
        bus.timeout[r_slot] <= w_res_to;
        bus.too_close[r_slot] <= w_res_to ? 1'b0 : r_cm < 9'(CLOSE_CM) ? 1'b1 :
                                 r_cm >= 9'(CLOSE_CM + HYST_CM) ? 1'b0 : bus.too_close[r_slot];
        bus.meas_id <= 3'(r_slot);
      end
    end
endmodule
